btn_event_bank: RTL and testbench



---
 rtl/btn_event_bank.sv | 164 ++++++++++++++++
 tb/tb_btn_event_bank.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_bank.sv
// Multi-channel push-button front end: synchronise, debounce on a shared tick,
// and emit clean level plus press/release/long/repeat pulses per channel.
module btn_event_bank #(
  parameter int CH           = 4,
  parameter int TICK_CNT     = 1000000,
  parameter int DB_SAMPLES   = 2,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CH-1:0] btn_in,
  output logic [CH-1:0] btn_level,
  output logic [CH-1:0] btn_press,
  output logic [CH-1:0] btn_release,
  output logic [CH-1:0] btn_long,
  output logic [CH-1:0] btn_repeat,
  output logic          tick
);

  localparam int PW = $clog2(TICK_CNT);
  localparam int AW = $clog2(DB_SAMPLES + 1);
  localparam int HW = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
  localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_CNT - 1);
  localparam logic [AW-1:0] AGREE_LAST = AW'(DB_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'((LONG_TICKS > 0) ? LONG_TICKS - 1 : 0);
  localparam logic [RW-1:0] REP_LAST   = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
  localparam logic [HW-1:0] HOLD_MAX   = {HW{1'b1}};
  localparam logic [RW-1:0] REP_MAX    = {RW{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} state_t;

  logic [PW-1:0] pre_cnt_reg;
  logic          tick_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else begin
      tick_reg    <= (pre_cnt_reg == PRE_LAST);
      pre_cnt_reg <= (pre_cnt_reg == PRE_LAST) ? '0 : pre_cnt_reg + PW'(1);
    end
  end

  assign tick = tick_reg;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic          sync1_reg, sync2_reg;
    logic          raw;
    logic          flip;
    logic [AW-1:0] agree_reg, agree_next;
    logic          level_reg, level_next;
    state_t        state_reg, state_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic [RW-1:0] rep_reg, rep_next;
    logic          press_reg, press_next;
    logic          release_reg, release_next;
    logic          long_reg, long_next;
    logic          repeat_reg, repeat_next;

    assign raw  = sync2_reg ^ ACTIVE_LOW;
    // The debounced level changes only on a tick that completes the agreement run.
    assign flip = tick_reg && (raw != level_reg) && (agree_reg == AGREE_LAST);

    always_comb begin
      agree_next   = agree_reg;
      level_next   = level_reg;
      state_next   = state_reg;
      hold_next    = hold_reg;
      rep_next     = rep_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      long_next    = 1'b0;
      repeat_next  = 1'b0;

      if (tick_reg) begin
        if (raw != level_reg) begin
          if (agree_reg == AGREE_LAST) begin
            agree_next = '0;
            level_next = ~level_reg;
          end else begin
            agree_next = agree_reg + AW'(1);
          end
        end else begin
          agree_next = '0;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (flip) begin
            state_next = ST_HELD;
            press_next = 1'b1;
            hold_next  = '0;
            rep_next   = '0;
          end
        end
        ST_HELD, ST_LONG: begin
          if (flip) begin
            // Release wins over any long/repeat maturing on the same tick.
            state_next   = ST_IDLE;
            release_next = 1'b1;
            hold_next    = '0;
            rep_next     = '0;
          end else if (tick_reg) begin
            if (hold_reg != HOLD_MAX) hold_next = hold_reg + HW'(1);
            if (state_reg == ST_HELD) begin
              if ((LONG_TICKS != 0) && (hold_reg == HOLD_LAST)) begin
                long_next  = 1'b1;
                state_next = ST_LONG;
                rep_next   = '0;
              end
            end else if ((REPEAT_TICKS != 0) && (rep_reg == REP_LAST)) begin
              repeat_next = 1'b1;
              rep_next    = '0;
            end else if (rep_reg != REP_MAX) begin
              rep_next = rep_reg + RW'(1);
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        sync1_reg   <= ACTIVE_LOW;
        sync2_reg   <= ACTIVE_LOW;
        agree_reg   <= '0;
        level_reg   <= 1'b0;
        state_reg   <= ST_IDLE;
        hold_reg    <= '0;
        rep_reg     <= '0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        long_reg    <= 1'b0;
        repeat_reg  <= 1'b0;
      end else begin
        sync1_reg   <= btn_in[gi];
        sync2_reg   <= sync1_reg;
        agree_reg   <= agree_next;
        level_reg   <= level_next;
        state_reg   <= state_next;
        hold_reg    <= hold_next;
        rep_reg     <= rep_next;
        press_reg   <= press_next;
        release_reg <= release_next;
        long_reg    <= long_next;
        repeat_reg  <= repeat_next;
      end
    end

    assign btn_level[gi]   = level_reg;
    assign btn_press[gi]   = press_reg;
    assign btn_release[gi] = release_reg;
    assign btn_long[gi]    = long_reg;
    assign btn_repeat[gi]  = repeat_reg;
  end

endmodule

// File: tb/tb_btn_event_bank.sv
// Directed bench for btn_event_bank: instance A is active-high, instance B
// active-low; an event monitor records pulse counts and the cycle they appear.
module tb_btn_event_bank;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  logic clock;
  logic reset_a, reset_b;
  logic [1:0] btn_a, btn_b;
  logic [1:0][1:0] lvl, prs, rel, lng, rpt;
  logic [1:0] tck;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;
  logic clr;

  int ev_cnt  [2][2][4];
  int ev_cyc  [2][2][4];
  int ev_first[2][2][4];
  int lvl_hi  [2][2];
  int excl    [2];
  logic [3:0] kinds_m;

  btn_event_bank #(
    .CH(2), .TICK_CNT(10), .DB_SAMPLES(2), .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW(1'b0)
  ) u_dut_a (
    .clock(clock), .reset(reset_a), .btn_in(btn_a),
    .btn_level(lvl[0]), .btn_press(prs[0]), .btn_release(rel[0]),
    .btn_long(lng[0]), .btn_repeat(rpt[0]), .tick(tck[0])
  );

  btn_event_bank #(
    .CH(2), .TICK_CNT(10), .DB_SAMPLES(2), .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .clock(clock), .reset(reset_b), .btn_in(btn_b),
    .btn_level(lvl[1]), .btn_press(prs[1]), .btn_release(rel[1]),
    .btn_long(lng[1]), .btn_repeat(rpt[1]), .tick(tck[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) ncyc <= ncyc + 1;

  always @(negedge clock) begin
    if (clr) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          lvl_hi[d][c] = 0;
          for (int k = 0; k < 4; k++) begin
            ev_cnt[d][c][k]   = 0;
            ev_cyc[d][c][k]   = 0;
            ev_first[d][c][k] = 0;
          end
        end
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        kinds_m = {rpt[d][c], lng[d][c], rel[d][c], prs[d][c]};
        if ($countones(kinds_m) > 1) excl[d] += 1;
        if (lvl[d][c] === 1'b1) lvl_hi[d][c] += 1;
        for (int k = 0; k < 4; k++) begin
          if (kinds_m[k] === 1'b1) begin
            if (ev_cnt[d][c][k] == 0) ev_first[d][c][k] = ncyc;
            ev_cnt[d][c][k] += 1;
            ev_cyc[d][c][k] = ncyc;
          end
        end
      end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    $display("cmp %s: observed %0d expected %0d", tag, obs, exp);
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_events();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  // Returns in the cycle where tick is high (just after the edge that set it).
  task automatic wait_tick(input int d);
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (tck[d] === 1'b1) return;
    end
    n_cmp++;
    n_bad++;
    $error("FAIL tick_timeout: observed no tick expected tick within 25 cycles");
  endtask

  int d0, p, r, first_tick;

  initial begin
    // Test 1: reset with pins driven, first tick timing.
    clr = 1'b1;
    reset_a = 1'b1; reset_b = 1'b1;
    btn_a = 2'b11; btn_b = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t1_reset_outs_a", {lvl[0], prs[0], rel[0], lng[0], rpt[0], tck[0]}, 0);
      chk("t1_reset_outs_b", {lvl[1], prs[1], rel[1], lng[1], rpt[1], tck[1]}, 0);
    end
    reset_a = 1'b0; reset_b = 1'b0; clr = 1'b0;
    btn_a = 2'b00;
    first_tick = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (tck[0] === 1'b1) begin
        first_tick = i;
        break;
      end
    end
    chk("t1_first_tick_cycles", first_tick, 10);
    step(1);
    chk("t1_tick_width", tck[0], 0);
    chk("t1_no_press_after_reset", ev_cnt[0][0][K_PRESS] + ev_cnt[0][1][K_PRESS], 0);

    // Test 2: clean press on ch0 then release after 40 cycles.
    clear_events();
    wait_tick(0);
    d0 = ncyc;
    btn_a[0] = 1'b1;
    step(20);
    chk("t2_level_before", lvl[0], 0);
    step(1);
    chk("t2_level_rise", lvl[0], 1);
    chk("t2_press_pulse", prs[0], 1);
    step(1);
    chk("t2_press_width", prs[0], 0);
    step(18);
    btn_a[0] = 1'b0;
    step(20);
    chk("t2_release_not_yet", rel[0], 0);
    step(1);
    chk("t2_release_pulse", rel[0], 1);
    chk("t2_level_fall", lvl[0], 0);
    step(4);
    chk("t2_press_count", ev_cnt[0][0][K_PRESS], 1);
    chk("t2_release_count", ev_cnt[0][0][K_REL], 1);
    chk("t2_long_count", ev_cnt[0][0][K_LONG], 0);
    chk("t2_press_latency", ev_cyc[0][0][K_PRESS] - d0, 21);
    chk("t2_release_latency", ev_cyc[0][0][K_REL] - d0, 61);

    // Test 3: short glitches never present on two consecutive ticks.
    clear_events();
    wait_tick(0);
    for (int i = 0; i < 6; i++) begin
      btn_a[0] = 1'b1;
      step(5);
      btn_a[0] = 1'b0;
      step(10);
    end
    step(25);
    chk("t3_level_never_high", lvl_hi[0][0], 0);
    chk("t3_no_press", ev_cnt[0][0][K_PRESS], 0);
    chk("t3_no_release", ev_cnt[0][0][K_REL], 0);

    // Test 4: ch1 long hold with repeats, then release.
    clear_events();
    wait_tick(0);
    d0 = ncyc;
    btn_a[1] = 1'b1;
    step(21);
    chk("t4_press_pulse", prs[0], 2'b10);
    p = ncyc;
    step(49);
    chk("t4_long_not_yet", lng[0], 0);
    step(1);
    chk("t4_long_pulse", lng[0], 2'b10);
    step(20);
    chk("t4_repeat1", rpt[0], 2'b10);
    step(20);
    chk("t4_repeat2", rpt[0], 2'b10);
    step(9);
    chk("t4_tick_at_release", tck[0], 1);
    btn_a[1] = 1'b0;
    step(11);
    chk("t4_repeat3", rpt[0], 2'b10);
    step(10);
    chk("t4_release_pulse", rel[0], 2'b10);
    chk("t4_repeat_off_at_release", rpt[0], 0);
    step(5);
    chk("t4_long_cycle", ev_cyc[0][1][K_LONG] - p, 50);
    chk("t4_first_repeat", ev_first[0][1][K_REP] - p, 70);
    chk("t4_repeat_count", ev_cnt[0][1][K_REP], 3);
    chk("t4_long_count", ev_cnt[0][1][K_LONG], 1);
    chk("t4_release_count", ev_cnt[0][1][K_REL], 1);
    chk("t4_release_cycle", ev_cyc[0][1][K_REL] - p, 120);

    // Test 6: ch0 press and ch1 release maturing on the same tick.
    clear_events();
    wait_tick(0);
    btn_a[1] = 1'b1;
    step(30);
    chk("t6_ch1_level", lvl[0], 2'b10);
    btn_a = 2'b01;
    step(21);
    chk("t6_press_ch0", prs[0], 2'b01);
    chk("t6_release_ch1", rel[0], 2'b10);
    chk("t6_no_long", lng[0], 0);
    chk("t6_no_repeat", rpt[0], 0);
    step(3);
    chk("t6_ch1_press_count", ev_cnt[0][1][K_PRESS], 1);
    chk("t6_same_cycle", ev_cyc[0][0][K_PRESS] - ev_cyc[0][1][K_REL], 0);
    btn_a = 2'b00;
    step(30);

    // Test 5: active-low instance, reset mid-hold, fresh press afterwards.
    clear_events();
    wait_tick(1);
    btn_b[0] = 1'b0;
    step(21);
    chk("t5_press_pulse", prs[1], 2'b01);
    chk("t5_level", lvl[1], 2'b01);
    step(50);
    chk("t5_long_pulse", lng[1], 2'b01);
    step(5);
    reset_b = 1'b1;
    step(1);
    chk("t5_reset_outs", {lvl[1], prs[1], rel[1], lng[1], rpt[1], tck[1]}, 0);
    r = ncyc;
    reset_b = 1'b0;
    step(10);
    chk("t5_tick_after_reset", tck[1], 1);
    step(11);
    chk("t5_fresh_press", prs[1], 2'b01);
    chk("t5_level_again", lvl[1], 2'b01);
    step(5);
    chk("t5_no_release", ev_cnt[1][0][K_REL], 0);
    chk("t5_press_count", ev_cnt[1][0][K_PRESS], 2);
    chk("t5_fresh_press_cycle", ev_cyc[1][0][K_PRESS] - r, 21);
    chk("t5_ch1_quiet", ev_cnt[1][1][K_PRESS], 0);

    chk("excl_a", excl[0], 0);
    chk("excl_b", excl[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
